// File: rtl/primitive_assembler_if.sv
// Decode-side strobes and rasterizer-side record stream of the primitive assembler.
interface primitive_assembler_if #(
    parameter int unsigned CNT_W = 5
);
    logic             SetVertex;
    logic [31:0]      Vertex;
    logic             StartPrimitive;
    logic [3:0]       PrimitiveType;
    logic             EndPrimitive;
    logic             Draw;
    logic             Prim_Ready;
    logic             Prim_Valid;
    logic [1:0]       Prim_Kind;
    logic [31:0]      Prim_V0;
    logic [31:0]      Prim_V1;
    logic [31:0]      Prim_V2;
    logic             Busy;
    logic             Done;
    logic             Error;
    logic [CNT_W-1:0] Vert_Count;

    modport master (
        output SetVertex, Vertex, StartPrimitive, PrimitiveType, EndPrimitive, Draw, Prim_Ready,
        input  Prim_Valid, Prim_Kind, Prim_V0, Prim_V1, Prim_V2, Busy, Done, Error, Vert_Count
    );

    modport slave (
        input  SetVertex, Vertex, StartPrimitive, PrimitiveType, EndPrimitive, Draw, Prim_Ready,
        output Prim_Valid, Prim_Kind, Prim_V0, Prim_V1, Prim_V2, Busy, Done, Error, Vert_Count
    );
endinterface

// File: rtl/primitive_assembler.sv
// Buffers vertices between StartPrimitive/EndPrimitive and replays them on Draw
// as point/line/triangle records over a valid/ready stream.
module primitive_assembler #(
    parameter int unsigned MAX_VERTS = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                CLK,
    input  logic                RESET,
    primitive_assembler_if.slave bus
);
    localparam int unsigned     IDX_W   = $clog2(MAX_VERTS);
    localparam int unsigned     IX_W    = CNT_W + 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VERTS);

    localparam logic [3:0] PT_POINTS = 4'd0;
    localparam logic [3:0] PT_LINES  = 4'd1;
    localparam logic [3:0] PT_LSTRIP = 4'd2;
    localparam logic [3:0] PT_TRIS   = 4'd3;
    localparam logic [3:0] PT_TSTRIP = 4'd4;

    typedef enum logic [1:0] {IDLE, COLLECT, CLOSED, EMIT} state_t;

    state_t           state_q;
    logic [3:0]       ptype_q;
    logic [CNT_W-1:0] vert_cnt_q;
    logic [CNT_W-1:0] rec_idx_q;
    logic             valid_q;
    logic [1:0]       kind_q;
    logic [31:0]      v0_q, v1_q, v2_q;
    logic             busy_q, done_q, error_q;
    logic [31:0]      buf_q [MAX_VERTS];

    logic start, setv, endp, draw, bad_type, wr_en_c;
    assign start    = bus.StartPrimitive;
    assign setv     = bus.SetVertex;
    assign endp     = bus.EndPrimitive;
    assign draw     = bus.Draw;
    assign bad_type = bus.PrimitiveType > PT_TSTRIP;
    assign wr_en_c  = (state_q == COLLECT) && !start && setv && (vert_cnt_q != MAX_CNT);

    // Vertex storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            buf_q[vert_cnt_q[IDX_W-1:0]] <= bus.Vertex;
        end
    end

    // Record count of the batch and buffer indices of record rec_idx_q.
    logic [IX_W-1:0]  rr;
    logic [IDX_W-1:0] i0, i1, i2;
    logic [CNT_W-1:0] rec_cnt;
    logic [1:0]       rec_kind;

    always_comb begin
        rr       = IX_W'(rec_idx_q);
        i0       = IDX_W'(rr);
        i1       = IDX_W'(rr);
        i2       = IDX_W'(rr);
        rec_cnt  = '0;
        rec_kind = 2'd0;
        case (ptype_q)
            PT_POINTS: begin
                rec_cnt = vert_cnt_q;
            end
            PT_LINES: begin
                rec_cnt  = vert_cnt_q >> 1;
                rec_kind = 2'd1;
                i0       = IDX_W'(rr << 1);
                i1       = IDX_W'((rr << 1) + IX_W'(1));
                i2       = IDX_W'((rr << 1) + IX_W'(1));
            end
            PT_LSTRIP: begin
                rec_cnt  = (vert_cnt_q == '0) ? '0 : vert_cnt_q - CNT_W'(1);
                rec_kind = 2'd1;
                i1       = IDX_W'(rr + IX_W'(1));
                i2       = IDX_W'(rr + IX_W'(1));
            end
            PT_TRIS: begin
                rec_cnt  = vert_cnt_q / CNT_W'(3);
                rec_kind = 2'd2;
                i0       = IDX_W'(rr + (rr << 1));
                i1       = IDX_W'(rr + (rr << 1) + IX_W'(1));
                i2       = IDX_W'(rr + (rr << 1) + IX_W'(2));
            end
            PT_TSTRIP: begin
                rec_cnt  = (vert_cnt_q < CNT_W'(2)) ? '0 : vert_cnt_q - CNT_W'(2);
                rec_kind = 2'd2;
                // Odd records swap the first two vertices to keep the winding consistent.
                if (rr[0]) begin
                    i0 = IDX_W'(rr + IX_W'(1));
                    i1 = IDX_W'(rr);
                end else begin
                    i0 = IDX_W'(rr);
                    i1 = IDX_W'(rr + IX_W'(1));
                end
                i2 = IDX_W'(rr + IX_W'(2));
            end
            default: begin
                rec_cnt = '0;
            end
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptype_q    <= '0;
            vert_cnt_q <= '0;
            rec_idx_q  <= '0;
            valid_q    <= 1'b0;
            kind_q     <= 2'd0;
            v0_q       <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptype_q    <= bus.PrimitiveType;
                        vert_cnt_q <= '0;
                        error_q    <= bad_type;
                        state_q    <= COLLECT;
                    end else if (setv || endp) begin
                        error_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        ptype_q    <= bus.PrimitiveType;
                        vert_cnt_q <= '0;
                        error_q    <= 1'b1;
                    end else if (setv) begin
                        if (vert_cnt_q == MAX_CNT) begin
                            error_q <= 1'b1;
                        end else begin
                            vert_cnt_q <= vert_cnt_q + CNT_W'(1);
                        end
                    end else if (endp) begin
                        state_q <= CLOSED;
                    end else if (draw) begin
                        error_q <= 1'b1;
                    end
                end
                CLOSED: begin
                    if (start) begin
                        ptype_q    <= bus.PrimitiveType;
                        vert_cnt_q <= '0;
                        error_q    <= error_q | bad_type;
                        state_q    <= COLLECT;
                    end else if (setv || endp) begin
                        error_q <= 1'b1;
                    end else if (draw) begin
                        rec_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    if (start || setv || endp || draw) begin
                        error_q <= 1'b1;
                    end
                    // Advance when nothing is presented yet or the current record transfers.
                    if (!valid_q || bus.Prim_Ready) begin
                        if (rec_idx_q == rec_cnt) begin
                            valid_q    <= 1'b0;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            vert_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            valid_q   <= 1'b1;
                            kind_q    <= rec_kind;
                            v0_q      <= buf_q[i0];
                            v1_q      <= buf_q[i1];
                            v2_q      <= buf_q[i2];
                            rec_idx_q <= rec_idx_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Prim_Valid = valid_q;
    assign bus.Prim_Kind  = kind_q;
    assign bus.Prim_V0    = v0_q;
    assign bus.Prim_V1    = v1_q;
    assign bus.Prim_V2    = v2_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
    assign bus.Vert_Count = vert_cnt_q;
endmodule

// File: tb/tb_primitive_assembler.sv
// Randomized and directed bench for primitive_assembler against a queue-based
// model of the record list each batch should produce.
module tb_primitive_assembler;
    localparam int unsigned MAX_VERTS = 16;
    localparam int unsigned CNT_W     = 5;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } rec_t;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_fail   = 0;

    primitive_assembler_if #(.CNT_W(CNT_W)) bus ();

    primitive_assembler #(.MAX_VERTS(MAX_VERTS), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    rec_t        got_q[$];
    rec_t        exp_q[$];
    logic [31:0] vq[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input rec_t r);
        return 128'({r.kind, r.v0, r.v1, r.v2});
    endfunction

    // Record collector plus hold-stability check while the rasterizer stalls.
    bit   pend = 1'b0;
    rec_t pend_rec;
    rec_t cur;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend = 1'b0;
        end else begin
            cur = '{bus.Prim_Kind, bus.Prim_V0, bus.Prim_V1, bus.Prim_V2};
            if (pend) begin
                check("hold_valid", 128'(bus.Prim_Valid), 128'(1));
                check("hold_data", pk(cur), pk(pend_rec));
            end
            if (bus.Prim_Valid && bus.Prim_Ready) got_q.push_back(cur);
            pend     = bus.Prim_Valid && !bus.Prim_Ready;
            pend_rec = cur;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [3:0] t);
        bus.StartPrimitive = 1'b1;
        bus.PrimitiveType  = t;
        tick();
        bus.StartPrimitive = 1'b0;
        vq.delete();
    endtask

    task automatic do_vertex(input logic [31:0] v);
        bus.SetVertex = 1'b1;
        bus.Vertex    = v;
        tick();
        bus.SetVertex = 1'b0;
        if (vq.size() < MAX_VERTS) vq.push_back(v);
    endtask

    task automatic do_end();
        bus.EndPrimitive = 1'b1;
        tick();
        bus.EndPrimitive = 1'b0;
    endtask

    // Expected records straight from the primitive-type rules.
    function automatic void build_exp(input logic [3:0] t);
        int n;
        n = vq.size();
        exp_q.delete();
        case (t)
            4'd0: for (int i = 0; i < n; i++) exp_q.push_back('{2'd0, vq[i], vq[i], vq[i]});
            4'd1: for (int k = 0; k < n / 2; k++) exp_q.push_back('{2'd1, vq[2*k], vq[2*k+1], vq[2*k+1]});
            4'd2: for (int i = 0; i < n - 1; i++) exp_q.push_back('{2'd1, vq[i], vq[i+1], vq[i+1]});
            4'd3: for (int k = 0; k < n / 3; k++) exp_q.push_back('{2'd2, vq[3*k], vq[3*k+1], vq[3*k+2]});
            4'd4: for (int i = 0; i < n - 2; i++) begin
                if (i % 2 == 0) exp_q.push_back('{2'd2, vq[i], vq[i+1], vq[i+2]});
                else            exp_q.push_back('{2'd2, vq[i+1], vq[i], vq[i+2]});
            end
            default: ;
        endcase
    endfunction

    task automatic compare_records(input string tag);
        check({tag, "_nrec"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_rec%0d", tag, i), pk(got_q[i]), pk(exp_q[i]));
        end
    endtask

    // mode 0: Ready always high, 1: Ready toggles, else random.
    task automatic run_draw(input int mode, input logic [3:0] t, input string tag);
        int cyc;
        bit done_seen;
        cyc       = 0;
        done_seen = 1'b0;
        build_exp(t);
        got_q.delete();
        bus.Draw = 1'b1;
        tick();
        bus.Draw = 1'b0;
        check({tag, "_busy"}, 128'(bus.Busy), 128'(1));
        while (!done_seen && cyc < 400) begin
            case (mode)
                0:       bus.Prim_Ready = 1'b1;
                1:       bus.Prim_Ready = (cyc % 2 == 0);
                default: bus.Prim_Ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
            if (bus.Done) done_seen = 1'b1;
        end
        check({tag, "_done"}, 128'(done_seen), 128'(1));
        if (exp_q.size() == 0) check({tag, "_zero_lat"}, 128'(cyc), 128'(1));
        check({tag, "_busy_end"}, 128'(bus.Busy), 128'(0));
        check({tag, "_valid_end"}, 128'(bus.Prim_Valid), 128'(0));
        check({tag, "_cnt_end"}, 128'(bus.Vert_Count), 128'(0));
        tick();
        check({tag, "_done_low"}, 128'(bus.Done), 128'(0));
        compare_records(tag);
        bus.Prim_Ready = 1'b0;
    endtask

    logic [3:0] rt;
    int         rn;
    bit         rerr;

    initial begin
        RESET              = 1'b1;
        bus.SetVertex      = 1'b0;
        bus.Vertex         = '0;
        bus.StartPrimitive = 1'b0;
        bus.PrimitiveType  = '0;
        bus.EndPrimitive   = 1'b0;
        bus.Draw           = 1'b0;
        bus.Prim_Ready     = 1'b0;
        #12;
        check("rst_valid", 128'(bus.Prim_Valid), 128'(0));
        check("rst_kind", 128'(bus.Prim_Kind), 128'(0));
        check("rst_data", 128'({bus.Prim_V0, bus.Prim_V1, bus.Prim_V2}), 128'(0));
        check("rst_flags", 128'({bus.Busy, bus.Done, bus.Error}), 128'(0));
        check("rst_cnt", 128'(bus.Vert_Count), 128'(0));
        RESET = 1'b0;
        tick();

        // Single triangle with exact cycle timing.
        do_start(4'd3);
        do_vertex(32'h00010002);
        do_vertex(32'h00030004);
        do_vertex(32'h00050006);
        do_end();
        check("t1_cnt", 128'(bus.Vert_Count), 128'(3));
        build_exp(4'd3);
        got_q.delete();
        bus.Prim_Ready = 1'b1;
        bus.Draw       = 1'b1;
        tick();
        bus.Draw = 1'b0;
        check("t1_busy_k", 128'(bus.Busy), 128'(1));
        check("t1_valid_k", 128'(bus.Prim_Valid), 128'(0));
        tick();
        check("t1_valid_k1", 128'(bus.Prim_Valid), 128'(1));
        check("t1_busy_k1", 128'(bus.Busy), 128'(1));
        check("t1_rec", 128'({bus.Prim_Kind, bus.Prim_V0, bus.Prim_V1, bus.Prim_V2}),
              128'({2'd2, 32'h00010002, 32'h00030004, 32'h00050006}));
        tick();
        check("t1_done", 128'(bus.Done), 128'(1));
        check("t1_busy_off", 128'(bus.Busy), 128'(0));
        check("t1_valid_off", 128'(bus.Prim_Valid), 128'(0));
        tick();
        check("t1_done_low", 128'(bus.Done), 128'(0));
        compare_records("t1");
        bus.Prim_Ready = 1'b0;

        // Triangle strip under a toggling Ready.
        do_start(4'd4);
        do_vertex(32'hAAAA0001);
        do_vertex(32'hBBBB0002);
        do_vertex(32'hCCCC0003);
        do_vertex(32'hDDDD0004);
        do_end();
        run_draw(1, 4'd4, "strip");

        // Lines with an odd trailing vertex.
        do_start(4'd1);
        for (int i = 0; i < 5; i++) do_vertex(32'h1000_0000 + 32'(i));
        do_end();
        run_draw(2, 4'd1, "lines");
        check("lines_err", 128'(bus.Error), 128'(0));

        // Buffer overflow saturates the count.
        do_start(4'd0);
        for (int i = 0; i < MAX_VERTS + 1; i++) do_vertex($urandom);
        check("ovf_cnt", 128'(bus.Vert_Count), 128'(MAX_VERTS));
        check("ovf_err", 128'(bus.Error), 128'(1));
        do_end();
        run_draw(0, 4'd0, "ovf");

        // Protocol errors: SetVertex in IDLE, Draw in COLLECT.
        bus.SetVertex = 1'b1;
        tick();
        bus.SetVertex = 1'b0;
        check("idle_sv_err", 128'(bus.Error), 128'(1));
        check("idle_sv_cnt", 128'(bus.Vert_Count), 128'(0));
        do_start(4'd3);
        check("start_clr_err", 128'(bus.Error), 128'(0));
        bus.Draw = 1'b1;
        tick();
        bus.Draw = 1'b0;
        check("coll_draw_err", 128'(bus.Error), 128'(1));
        check("coll_draw_busy", 128'(bus.Busy), 128'(0));
        check("coll_draw_valid", 128'(bus.Prim_Valid), 128'(0));
        do_end();
        run_draw(0, 4'd3, "empty");

        // Reset in the middle of emission.
        do_start(4'd3);
        for (int i = 0; i < 9; i++) do_vertex(32'h2000_0000 + 32'(i));
        do_end();
        bus.Prim_Ready = 1'b1;
        bus.Draw       = 1'b1;
        tick();
        bus.Draw = 1'b0;
        tick();
        tick();
        check("mid_valid", 128'(bus.Prim_Valid), 128'(1));
        #2;
        RESET = 1'b1;
        #1;
        check("arst_valid", 128'(bus.Prim_Valid), 128'(0));
        check("arst_flags", 128'({bus.Busy, bus.Done, bus.Error}), 128'(0));
        check("arst_cnt", 128'(bus.Vert_Count), 128'(0));
        check("arst_data", 128'({bus.Prim_Kind, bus.Prim_V0, bus.Prim_V1, bus.Prim_V2}), 128'(0));
        #1;
        RESET          = 1'b0;
        bus.Prim_Ready = 1'b0;
        tick();
        do_start(4'd2);
        for (int i = 0; i < 4; i++) do_vertex($urandom);
        do_end();
        run_draw(2, 4'd2, "post_rst");

        // Random batches, occasionally with an unsupported type or overflow.
        for (int it = 0; it < 25; it++) begin
            rt   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            rn   = $urandom_range(0, 18);
            rerr = (rt > 4'd4) || (rn > MAX_VERTS);
            do_start(rt);
            check("rnd_start_err", 128'(bus.Error), 128'(rt > 4'd4));
            for (int j = 0; j < rn; j++) begin
                if ($urandom_range(0, 2) == 0) tick();
                do_vertex($urandom);
            end
            do_end();
            check("rnd_cnt", 128'(bus.Vert_Count), 128'((rn > MAX_VERTS) ? MAX_VERTS : rn));
            run_draw(2, rt, $sformatf("rnd%0d", it));
            check("rnd_err", 128'(bus.Error), 128'(rerr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
